sha_ctrl: RTL and testbench

SHA_CTRL -- requirements
Module: sha_ctrl

---
 rtl/sha_pkg.sv | 13 +
 rtl/sha_ctrl_if.sv | 27 ++
 rtl/sha_ctrl_wdog.sv | 18 +
 rtl/sha_ctrl.sv | 77 +++++++
 tb/tb_sha_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha_pkg.sv
// sha_pkg: shared constants and FSM encoding for the SHA-256 controller.
// The ERR state exists only when SHA_CTRL_TIMEOUT_EN is defined.
package sha_pkg;
  localparam int WORD_W = 32;
  localparam int NUM_WORDS = 8;
  localparam int BLOCK_BITS = 512;
  typedef enum logic [2:0] {
    IDLE, START, WAIT_CORE, NEXT, DRAIN, DONE
`ifdef SHA_CTRL_TIMEOUT_EN
    , ERR
`endif
  } state_t;
endpackage

// File: rtl/sha_ctrl_if.sv
// sha_ctrl_if: block, core and digest-output signals of the SHA controller; master is the controller side.
interface sha_ctrl_if #(parameter int WORD_W = sha_pkg::WORD_W);
  logic              blk_valid_in;
  logic              blk_last_in;
  logic              blk_ready_out;
  logic              core_init_out;
  logic              core_start_out;
  logic              core_done_in;
  logic [2:0]        digest_sel_out;
  logic [WORD_W-1:0] digest_word_in;
  logic [WORD_W-1:0] out_word_out;
  logic              out_dv_out;
  logic              out_ready_in;
  logic              busy_out;
  logic              done_out;
  logic              err_out;
  modport master (
    input  blk_valid_in, blk_last_in, core_done_in, digest_word_in, out_ready_in,
    output blk_ready_out, core_init_out, core_start_out, digest_sel_out, out_word_out,
           out_dv_out, busy_out, done_out, err_out
  );
  modport slave (
    output blk_valid_in, blk_last_in, core_done_in, digest_word_in, out_ready_in,
    input  blk_ready_out, core_init_out, core_start_out, digest_sel_out, out_word_out,
           out_dv_out, busy_out, done_out, err_out
  );
endinterface

// File: rtl/sha_ctrl_wdog.sv
// sha_ctrl_wdog: cycle counter that flags expiry after TIMEOUT_CYCLES-1 enabled cycles since the last clear.
module sha_ctrl_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + CW'(1);
  assign expired = cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/sha_ctrl.sv
// sha_ctrl: SHA-256 block sequencer -- hands blocks to the core, then drains the digest word by word.
// Define SHA_CTRL_TIMEOUT_EN to add the core watchdog (sha_ctrl_wdog) and the ERR state.
module sha_ctrl #(
  parameter int WORD_W = sha_pkg::WORD_W,
  parameter int NUM_WORDS = sha_pkg::NUM_WORDS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid_in,
  input  logic              blk_last_in,
  output logic              blk_ready_out,
  output logic              core_init_out,
  output logic              core_start_out,
  input  logic              core_done_in,
  output logic [2:0]        digest_sel_out,
  input  logic [WORD_W-1:0] digest_word_in,
  output logic [WORD_W-1:0] out_word_out,
  output logic              out_dv_out,
  input  logic              out_ready_in,
  output logic              busy_out,
  output logic              done_out,
  output logic              err_out
);
  import sha_pkg::*;
  localparam logic [2:0] LAST_WORD = 3'(NUM_WORDS - 1);
  state_t state, state_nx;
  logic [2:0] word_cnt;
  logic last_r;
`ifdef SHA_CTRL_TIMEOUT_EN
  logic expired;
  sha_ctrl_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk, .rst, .clr(state != WAIT_CORE), .en(state == WAIT_CORE), .expired
  );
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      word_cnt <= '0;
      last_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == START) last_r <= blk_last_in;
      if (state == WAIT_CORE && core_done_in) word_cnt <= '0;
      else if (state == DRAIN && out_ready_in) word_cnt <= word_cnt + 3'd1;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = blk_valid_in ? START : IDLE;
      START:     state_nx = WAIT_CORE;
`ifdef SHA_CTRL_TIMEOUT_EN
      // A completion in the expiry cycle takes priority over the timeout.
      WAIT_CORE: state_nx = core_done_in ? (last_r ? DRAIN : NEXT) : expired ? ERR : WAIT_CORE;
`else
      WAIT_CORE: state_nx = core_done_in ? (last_r ? DRAIN : NEXT) : WAIT_CORE;
`endif
      NEXT:      state_nx = blk_valid_in ? START : NEXT;
      DRAIN:     state_nx = (out_ready_in && word_cnt == LAST_WORD) ? DONE : DRAIN;
      default:   state_nx = IDLE;
    endcase
  end
  // core_init is the one decode that looks at an input: IV load must coincide with block acceptance.
  assign core_init_out = !rst && state == IDLE && blk_valid_in;
  assign core_start_out = state == START;
  assign blk_ready_out = state == START;
  assign out_dv_out = state == DRAIN;
  assign digest_sel_out = out_dv_out ? word_cnt : 3'd0;
  assign out_word_out = out_dv_out ? digest_word_in : '0;
  assign busy_out = state != IDLE;
  assign done_out = state == DONE;
`ifdef SHA_CTRL_TIMEOUT_EN
  assign err_out = state == ERR;
`else
  assign err_out = 1'b0;
`endif
endmodule

// File: tb/tb_sha_ctrl.sv
// tb_sha_ctrl: scenario bench for sha_ctrl; digest words are queued when the last core_done is driven
// and popped as the serializer accepts them. Watchdog scenarios need SHA_CTRL_TIMEOUT_EN.
module tb_sha_ctrl;
  localparam int W = 32;
`ifdef SHA_CTRL_TIMEOUT_EN
  localparam int LAT1 = 14;
`else
  localparam int LAT1 = 64;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  sha_ctrl_if #(.WORD_W(W)) sif ();
  logic [W-1:0] mem [8];
  assign sif.digest_word_in = mem[sif.digest_sel_out];
  sha_ctrl #(.WORD_W(W), .NUM_WORDS(8), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .blk_valid_in   (sif.blk_valid_in),
    .blk_last_in    (sif.blk_last_in),
    .blk_ready_out  (sif.blk_ready_out),
    .core_init_out  (sif.core_init_out),
    .core_start_out (sif.core_start_out),
    .core_done_in   (sif.core_done_in),
    .digest_sel_out (sif.digest_sel_out),
    .digest_word_in (sif.digest_word_in),
    .out_word_out   (sif.out_word_out),
    .out_dv_out     (sif.out_dv_out),
    .out_ready_in   (sif.out_ready_in),
    .busy_out       (sif.busy_out),
    .done_out       (sif.done_out),
    .err_out        (sif.err_out)
  );
  int vectors = 0;
  int miscompares = 0;
  int n_init = 0, n_start = 0, n_done = 0, n_err = 0, n_ready = 0;
  int sel_q[$];
  logic [W-1:0] word_q[$];
  always @(negedge clk) begin
    n_init  += int'(sif.core_init_out);
    n_start += int'(sif.core_start_out);
    n_done  += int'(sif.done_out);
    n_err   += int'(sif.err_out);
    n_ready += int'(sif.blk_ready_out);
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_block(input bit last, input bit first, input bit noisy, input int lat);
    sif.blk_valid_in = 1'b1;
    sif.blk_last_in = last;
    @(negedge clk);
    vectors++;
    if (sif.core_init_out !== first) begin
      miscompares++;
      $display("FAIL core_init: got %b want %b", sif.core_init_out, first);
    end
    tick;
    sif.blk_valid_in = noisy;
    sif.core_done_in = noisy;
    @(negedge clk);
    vectors++;
    if ({sif.core_start_out, sif.blk_ready_out} !== 2'b11) begin
      miscompares++;
      $display("FAIL start_pulse: got start=%b ready=%b want 1 1", sif.core_start_out, sif.blk_ready_out);
    end
    tick;
    sif.core_done_in = 1'b0;
    sif.blk_last_in = 1'b0;
    repeat (lat) begin
      @(negedge clk);
      vectors++;
      if ({sif.out_dv_out, sif.blk_ready_out, sif.core_start_out, sif.busy_out} !== 4'b0001) begin
        miscompares++;
        $display("FAIL wait_core: got dv/ready/start/busy=%b want 0001",
                 {sif.out_dv_out, sif.blk_ready_out, sif.core_start_out, sif.busy_out});
      end
      tick;
    end
    sif.blk_valid_in = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    sif.core_done_in = 1'b1;
    if (last) for (int i = 0; i < 8; i++) begin
      sel_q.push_back(i);
      word_q.push_back(mem[i]);
    end
    tick;
    sif.core_done_in = 1'b0;
    @(negedge clk);
    vectors++;
    if (sif.out_dv_out !== last) begin
      miscompares++;
      $display("FAIL done_to_dv: got %b want %b", sif.out_dv_out, last);
    end
    tick;
  endtask
  task automatic drain(input int stall_at, input int stall_len);
    int stalls = 0;
    int guard = 0;
    while (sel_q.size() > 0 && guard < 200) begin
      guard++;
      sif.out_ready_in = !(int'(sif.digest_sel_out) == stall_at && stalls < stall_len);
      if (!sif.out_ready_in) stalls++;
      @(negedge clk);
      vectors++;
      if (sif.out_dv_out !== 1'b1 || sif.digest_sel_out !== 3'(sel_q[0]) || sif.out_word_out !== word_q[0]) begin
        miscompares++;
        $display("FAIL drain_word: got dv=%b sel=%0d word=%h want dv=1 sel=%0d word=%h",
                 sif.out_dv_out, sif.digest_sel_out, sif.out_word_out, sel_q[0], word_q[0]);
      end
      if (sif.out_ready_in) begin
        void'(sel_q.pop_front());
        void'(word_q.pop_front());
      end
      tick;
    end
    sif.out_ready_in = 1'b0;
    if (guard >= 200) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d words left want 0", sel_q.size());
      sel_q.delete();
      word_q.delete();
    end
    @(negedge clk);
    vectors++;
    if (sif.done_out !== 1'b1 || sif.out_dv_out !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: got done=%b dv=%b want 1 0", sif.done_out, sif.out_dv_out);
    end
    tick;
    @(negedge clk);
    vectors++;
    if ({sif.busy_out, sif.done_out} !== 2'b00) begin
      miscompares++;
      $display("FAIL back_to_idle: got busy=%b done=%b want 0 0", sif.busy_out, sif.done_out);
    end
    tick;
  endtask
  task automatic check_zero_outputs(input string tag);
    vectors++;
    if ({sif.blk_ready_out, sif.core_init_out, sif.core_start_out, sif.out_dv_out,
         sif.busy_out, sif.done_out, sif.err_out} !== 7'd0) begin
      miscompares++;
      $display("FAIL %s_flags: got %b want 0000000", tag, {sif.blk_ready_out, sif.core_init_out,
               sif.core_start_out, sif.out_dv_out, sif.busy_out, sif.done_out, sif.err_out});
    end
    vectors++;
    if (sif.digest_sel_out !== 3'd0 || sif.out_word_out !== '0) begin
      miscompares++;
      $display("FAIL %s_data: got sel=%0d word=%h want 0 0", tag, sif.digest_sel_out, sif.out_word_out);
    end
  endtask
  task automatic test_reset;
    sif.blk_valid_in = 1'b1;
    sif.blk_last_in = 1'b1;
    sif.core_done_in = 1'b1;
    sif.out_ready_in = 1'b1;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    sif.blk_valid_in = 1'b0;
    sif.blk_last_in = 1'b0;
    sif.core_done_in = 1'b0;
    sif.out_ready_in = 1'b0;
    rst = 1'b0;
    tick;
  endtask
  task automatic test_single;
    int i0 = n_init, s0 = n_start, d0 = n_done, r0 = n_ready;
    send_block(1'b1, 1'b1, 1'b0, LAT1);
    drain(-1, 0);
    vectors++;
    if (n_init - i0 != 1 || n_start - s0 != 1 || n_done - d0 != 1 || n_ready - r0 != 1) begin
      miscompares++;
      $display("FAIL single_counts: got init=%0d start=%0d done=%0d ready=%0d want 1 1 1 1",
               n_init - i0, n_start - s0, n_done - d0, n_ready - r0);
    end
  endtask
  task automatic test_multi;
    int i0 = n_init, s0 = n_start, d0 = n_done;
    send_block(1'b0, 1'b1, 1'b0, 10);
    send_block(1'b0, 1'b0, 1'b0, 5);
    send_block(1'b1, 1'b0, 1'b0, 7);
    drain(-1, 0);
    vectors++;
    if (n_init - i0 != 1 || n_start - s0 != 3 || n_done - d0 != 1) begin
      miscompares++;
      $display("FAIL multi_counts: got init=%0d start=%0d done=%0d want 1 3 1",
               n_init - i0, n_start - s0, n_done - d0);
    end
  endtask
  task automatic test_backpressure;
    send_block(1'b1, 1'b1, 1'b0, 3);
    drain(3, 5);
  endtask
  task automatic test_stray;
    int s0;
    send_block(1'b0, 1'b1, 1'b0, 4);
    s0 = n_start;
    sif.core_done_in = 1'b1;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({sif.busy_out, sif.out_dv_out, sif.core_start_out} !== 3'b100) begin
        miscompares++;
        $display("FAIL stray_next: got busy/dv/start=%b want 100",
                 {sif.busy_out, sif.out_dv_out, sif.core_start_out});
      end
      tick;
      sif.core_done_in = 1'b0;
    end
    send_block(1'b1, 1'b0, 1'b1, 6);
    drain(-1, 0);
    vectors++;
    if (n_start - s0 != 1) begin
      miscompares++;
      $display("FAIL stray_starts: got %0d want 1", n_start - s0);
    end
  endtask
  task automatic test_reset_mid;
    int g = 0;
    send_block(1'b1, 1'b1, 1'b0, 2);
    sif.out_ready_in = 1'b1;
    while (sif.digest_sel_out != 3'd4 && g < 20) begin
      tick;
      g++;
    end
    vectors++;
    if (sif.digest_sel_out !== 3'd4 || sif.out_dv_out !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_drain_reach: got sel=%0d dv=%b want 4 1", sif.digest_sel_out, sif.out_dv_out);
    end
    sif.blk_valid_in = 1'b1;
    rst = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    sel_q.delete();
    word_q.delete();
    sif.out_ready_in = 1'b0;
    sif.blk_valid_in = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    send_block(1'b1, 1'b1, 1'b0, 3);
    drain(-1, 0);
  endtask
`ifdef SHA_CTRL_TIMEOUT_EN
  task automatic test_watchdog;
    int e0 = n_err;
    sif.blk_valid_in = 1'b1;
    sif.blk_last_in = 1'b1;
    tick;
    sif.blk_valid_in = 1'b0;
    tick;
    sif.blk_last_in = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      vectors++;
      if ({sif.err_out, sif.busy_out} !== 2'b01) begin
        miscompares++;
        $display("FAIL wdog_wait%0d: got err/busy=%b want 01", i, {sif.err_out, sif.busy_out});
      end
      tick;
    end
    @(negedge clk);
    vectors++;
    if (sif.err_out !== 1'b1) begin
      miscompares++;
      $display("FAIL wdog_err: got %b want 1", sif.err_out);
    end
    tick;
    @(negedge clk);
    vectors++;
    if ({sif.err_out, sif.busy_out} !== 2'b00 || n_err - e0 != 1) begin
      miscompares++;
      $display("FAIL wdog_idle: got err/busy=%b pulses=%0d want 00 1", {sif.err_out, sif.busy_out}, n_err - e0);
    end
    tick;
    send_block(1'b1, 1'b1, 1'b0, 15);
    drain(-1, 0);
    vectors++;
    if (n_err - e0 != 1) begin
      miscompares++;
      $display("FAIL wdog_race: got %0d err pulses want 1", n_err - e0);
    end
  endtask
`else
  task automatic test_no_timeout;
    send_block(1'b1, 1'b1, 1'b0, 40);
    drain(-1, 0);
    vectors++;
    if (n_err != 0) begin
      miscompares++;
      $display("FAIL no_wdog_err: got %0d err pulses want 0", n_err);
    end
  endtask
`endif
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset;
    test_single;
    test_multi;
    test_backpressure;
    test_stray;
    test_reset_mid;
`ifdef SHA_CTRL_TIMEOUT_EN
    test_watchdog;
`else
    test_no_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
